// File: rtl/axis_output_pipe_pkg.sv
// Shared constants for the conv-engine stream pipes: beat geometry, word width
// and the tuser bit that marks configuration beats.
package axis_output_pipe_pkg;

    localparam int AOP_WORD_WIDTH = 8;
    localparam int AOP_COPIES     = 2;
    localparam int AOP_GROUPS     = 2;
    localparam int AOP_MEMBERS    = 8;
    localparam int AOP_IN_WORDS   = AOP_COPIES * AOP_GROUPS * AOP_MEMBERS;
    localparam int AOP_OUT_WORDS  = 8;

    localparam int AOP_TUSER_W          = 1;
    localparam int AOP_TUSER_IS_CONFIG  = 0;

    // Counter width for n narrow beats; never narrower than one bit.
    function automatic int beat_bits(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axis_pingpong_buffer.sv
// Two-slot ping-pong buffer carrying a data word plus a last flag.
// Push and pop may coincide; the caller never pushes when full or pops when empty.
module axis_pingpong_buffer #(
    parameter int DATA_W = 256
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_push_last,
    input  logic              i_pop,
    output logic              o_full,
    output logic              o_empty,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_last
);

    logic [DATA_W-1:0] r_data [2];
    logic              r_last [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < 2; i++) begin
                r_data[i] <= '0;
                r_last[i] <= 1'b0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_data[r_wr_ptr] <= i_push_data;
                r_last[r_wr_ptr] <= i_push_last;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_full    = (r_count == 2'd2);
    assign o_empty   = (r_count == 2'd0);
    assign o_rd_data = r_data[r_rd_ptr];
    assign o_rd_last = r_last[r_rd_ptr];

endmodule

// File: rtl/axis_output_pipe.sv
// Serializes wide conv-engine result beats onto a narrow AXI-Stream master,
// buffering two wide beats and dropping configuration beats.
module axis_output_pipe
    import axis_output_pipe_pkg::*;
#(
    parameter int COPIES     = AOP_COPIES,
    parameter int GROUPS     = AOP_GROUPS,
    parameter int MEMBERS    = AOP_MEMBERS,
    parameter int WORD_WIDTH = AOP_WORD_WIDTH,
    parameter int OUT_WORDS  = AOP_OUT_WORDS
) (
    input  logic                                     aclk,
    input  logic                                     areset,
    output logic                                     s_axis_tready,
    input  logic                                     s_axis_tvalid,
    input  logic                                     s_axis_tlast,
    input  logic [AOP_TUSER_W-1:0]                   s_axis_tuser,
    input  logic [COPIES*GROUPS*MEMBERS*WORD_WIDTH-1:0] s_axis_tdata,
    input  logic                                     m_axis_tready,
    output logic                                     m_axis_tvalid,
    output logic                                     m_axis_tlast,
    output logic [OUT_WORDS*WORD_WIDTH/8-1:0]        m_axis_tkeep,
    output logic [OUT_WORDS*WORD_WIDTH-1:0]          m_axis_tdata
);

    localparam int IN_WORDS  = COPIES * GROUPS * MEMBERS;
    localparam int IN_BITS   = IN_WORDS * WORD_WIDTH;
    localparam int OUT_BITS  = OUT_WORDS * WORD_WIDTH;
    localparam int BEATS     = IN_WORDS / OUT_WORDS;
    localparam int BITS_BEAT = beat_bits(BEATS);
    localparam logic [BITS_BEAT-1:0] BEAT_LAST = BITS_BEAT'(BEATS - 1);

    if ((IN_WORDS % OUT_WORDS) != 0) begin : g_bad_ratio
        $error("axis_output_pipe: IN_WORDS must be a multiple of OUT_WORDS");
    end

    logic                              w_full;
    logic                              w_empty;
    logic [IN_BITS-1:0]                w_rd_data;
    logic                              w_rd_last;
    logic [BEATS-1:0][OUT_BITS-1:0]    w_slices;
    logic                              w_in_hs;
    logic                              w_push;
    logic                              w_out_hs;
    logic                              w_last_beat;
    logic                              w_pop;
    logic [BITS_BEAT-1:0]              r_beat;

    // Config beats complete the input handshake but never reach the buffer.
    assign w_in_hs     = s_axis_tvalid && s_axis_tready;
    assign w_push      = w_in_hs && !s_axis_tuser[AOP_TUSER_IS_CONFIG];
    assign w_out_hs    = m_axis_tvalid && m_axis_tready;
    assign w_last_beat = (r_beat == BEAT_LAST);
    assign w_pop       = w_out_hs && w_last_beat;

    axis_pingpong_buffer #(
        .DATA_W (IN_BITS)
    ) u_buffer (
        .i_clk       (aclk),
        .i_rst       (areset),
        .i_push      (w_push),
        .i_push_data (s_axis_tdata),
        .i_push_last (s_axis_tlast),
        .i_pop       (w_pop),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_rd_data   (w_rd_data),
        .o_rd_last   (w_rd_last)
    );

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_beat <= '0;
        end else if (w_out_hs) begin
            r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
        end
    end

    // Ready comes from buffer occupancy only, held low while in reset.
    assign s_axis_tready = !areset && !w_full;

    assign w_slices      = w_rd_data;
    assign m_axis_tvalid = !w_empty;
    assign m_axis_tdata  = w_slices[r_beat];
    assign m_axis_tlast  = w_rd_last && w_last_beat;
    assign m_axis_tkeep  = '1;

endmodule
